// File: rtl/cordic_iter_ctrl_if.sv
// Handshake and LUT/datapath control bundle for the CORDIC iteration controller.
// master: the requester/datapath side; slave: the controller itself.
interface cordic_iter_ctrl_if;
  logic       start;
  logic       lut_en;
  logic [4:0] lut_addr;
  logic       load_operands;
  logic       iter_valid;
  logic [4:0] shift_amt;
  logic       busy;
  logic       done;

  modport master (
    output start,
    input  lut_en, lut_addr, load_operands, iter_valid, shift_amt, busy, done
  );

  modport slave (
    input  start,
    output lut_en, lut_addr, load_operands, iter_valid, shift_amt, busy, done
  );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration controller: sequences ITERATIONS arctan-LUT reads and
// presents each ROM word to the datapath one cycle later with its shift count.
// States IDLE -> RUN -> DRAIN -> DONE -> IDLE; every output is registered.
// Optional feature: define CORDIC_CTRL_ABORT_EN to add an 'abort' input that
// returns the controller to IDLE without a done pulse.
module cordic_iter_ctrl #(
  parameter int ITERATIONS = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CORDIC_CTRL_ABORT_EN
  input  logic abort,
`endif
  cordic_iter_ctrl_if.slave bus
);

  // Six-bit count so that ITERATIONS=32 can be represented without wrapping.
  localparam logic [5:0] LP_ITER = 6'(ITERATIONS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [5:0] r_cnt, w_cnt_nxt;

  logic       r_lut_en,     w_lut_en_nxt;
  logic [4:0] r_lut_addr,   w_lut_addr_nxt;
  logic       r_load,       w_load_nxt;
  logic       r_iter_valid, w_iter_valid_nxt;
  logic [4:0] r_shift,      w_shift_nxt;
  logic       r_busy,       w_busy_nxt;
  logic       r_done,       w_done_nxt;

  logic       w_abort;

`ifdef CORDIC_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 6'd0;
      r_lut_en     <= 1'b0;
      r_lut_addr   <= 5'd0;
      r_load       <= 1'b0;
      r_iter_valid <= 1'b0;
      r_shift      <= 5'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lut_en     <= w_lut_en_nxt;
      r_lut_addr   <= w_lut_addr_nxt;
      r_load       <= w_load_nxt;
      r_iter_valid <= w_iter_valid_nxt;
      r_shift      <= w_shift_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next-state and next-output decode. The ROM has one cycle of read latency,
  // so iter_valid/shift_amt simply follow last cycle's lut_en/lut_addr.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_lut_en_nxt     = 1'b0;
    w_lut_addr_nxt   = 5'd0;
    w_load_nxt       = 1'b0;
    w_iter_valid_nxt = r_lut_en;
    w_shift_nxt      = r_lut_en ? r_lut_addr : 5'd0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 6'd0;
        if (bus.start && !w_abort) begin
          // Address 0 is issued together with the operand load.
          w_state_nxt    = S_RUN;
          w_cnt_nxt      = 6'd1;
          w_lut_en_nxt   = 1'b1;
          w_lut_addr_nxt = 5'd0;
          w_load_nxt     = 1'b1;
          w_busy_nxt     = 1'b1;
        end
      end
      S_RUN: begin
        w_busy_nxt = 1'b1;
        if (r_cnt >= LP_ITER) begin
          // Last address already issued; wait for its ROM word.
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = 6'd0;
        end else begin
          w_lut_en_nxt   = 1'b1;
          w_lut_addr_nxt = r_cnt[4:0];
          w_cnt_nxt      = r_cnt + 6'd1;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_DONE;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 6'd0;
      end
    endcase

    // Abort wins over everything outside IDLE: drop the operation silently.
    if (w_abort && (r_state != S_IDLE)) begin
      w_state_nxt      = S_IDLE;
      w_cnt_nxt        = 6'd0;
      w_lut_en_nxt     = 1'b0;
      w_lut_addr_nxt   = 5'd0;
      w_load_nxt       = 1'b0;
      w_iter_valid_nxt = 1'b0;
      w_shift_nxt      = 5'd0;
      w_busy_nxt       = 1'b0;
      w_done_nxt       = 1'b0;
    end
  end

  assign bus.lut_en        = r_lut_en;
  assign bus.lut_addr      = r_lut_addr;
  assign bus.load_operands = r_load;
  assign bus.iter_valid    = r_iter_valid;
  assign bus.shift_amt     = r_shift;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 Parameter ITERATIONS, default 32, meaning number of CORDIC micro-rotations per operation; legal range 1..32.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 lut_en  output  1  enable to the 64-bit arctan LUT ROM.
REQ-006 lut_addr  output  5  iteration index driven to the ROM address.
REQ-007 load_operands  output  1  one-cycle pulse; datapath loads x/y/z operands.
REQ-008 iter_valid  output  1  ROM data_out is valid this cycle; datapath performs one micro-rotation.
REQ-009 shift_amt  output  5  shift count for this iteration, aligned with iter_valid.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DRAIN and DONE, with all outputs registered.
REQ-013 Timing reference: start high at edge 0 in IDLE; cycle c is the interval after edge c.
REQ-014 Start acceptance SHALL move IDLE->RUN, giving load_operands=1 in cycle 1 only and busy=1 from cycle 1.
REQ-015 In RUN, lut_en SHALL be 1 and lut_addr SHALL equal i in cycle i+1, for i = 0..ITERATIONS-1.
REQ-016 After lut_addr = ITERATIONS-1 has been issued, the FSM SHALL go RUN->DRAIN, with lut_en=0 and lut_addr=0 from cycle ITERATIONS+1.
REQ-017 iter_valid SHALL be 1 in cycles 2..ITERATIONS+1, with shift_amt = cycle-2, matching the ROM's one-cycle read latency.
REQ-018 The iteration counter SHALL be 6 bits wide, so that ITERATIONS=32 terminates without 5-bit wrap-around; lut_addr SHALL never exceed ITERATIONS-1.
REQ-019 DRAIN SHALL last exactly until the last iter_valid cycle, then go to DONE; done=1 in cycle ITERATIONS+2 only.
REQ-020 DONE->IDLE SHALL be unconditional; busy=0 from cycle ITERATIONS+3.
REQ-021 start SHALL be ignored in RUN, DRAIN and DONE (no queuing); the earliest next acceptance is at edge ITERATIONS+3.
REQ-022 With ITERATIONS=1, RUN SHALL last one cycle, giving iter_valid in cycle 2 only and done in cycle 3.
REQ-023 When idle, lut_en, iter_valid, load_operands and done SHALL be 0, and lut_addr and shift_amt SHALL be 0.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, clear the counter, and force every output to 0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abandon the operation with no done pulse; after release the block SHALL wait for a new start.
REQ-026 After reset deassertion, the first start seen at a clock edge SHALL be accepted normally.

Configuration
REQ-027 Macro CORDIC_CTRL_ABORT_EN SHALL, when defined, add input port abort (1 bit).
REQ-028 With CORDIC_CTRL_ABORT_EN defined, abort high at an edge in RUN, DRAIN or DONE SHALL give IDLE next cycle, with all outputs 0 and no done pulse.
REQ-029 With CORDIC_CTRL_ABORT_EN defined, abort high in IDLE SHALL block acceptance of a simultaneous start.
REQ-030 Without CORDIC_CTRL_ABORT_EN, the abort port SHALL not exist and every accepted operation SHALL run to done.

Verification
REQ-031 Reset then start pulse, ITERATIONS=32: lut_addr steps 0..31 in cycles 1..32; iter_valid with shift_amt 0..31 in cycles 2..33; done in cycle 34 only.
REQ-032 Connect the LUT ROM: in the cycle with shift_amt=0, ROM data_out = 64'h3fe921fb54442d18; with shift_amt=31, data_out = 64'h3e00000000000000.
REQ-033 Hold start high continuously: operations begin at edges 0, 35, 70; busy drops for exactly one cycle between operations; done count equals operation count.
REQ-034 Assert rst_n low in cycle 10 of an operation: all outputs are 0 asynchronously; no done pulse; a new start after release runs the full sequence.
REQ-035 ITERATIONS=1: load_operands in cycle 1, iter_valid with shift_amt=0 in cycle 2, done in cycle 3, busy low in cycle 4.
REQ-036 CORDIC_CTRL_ABORT_EN defined, abort in cycle 5: outputs are 0 from cycle 6 with no done; abort together with start in IDLE leaves busy at 0.
